// File: rtl/jtbubl_snd_comm.sv
// jtbubl_snd_comm
//   Main-CPU side of the main/sound command link. Command bytes written by the
//   main CPU are queued in a small FIFO and handed to the sound CPU one at a
//   time; the next byte only goes out after the sound CPU has taken the
//   previous one (snd_flag round trip). Replies from the sound CPU are captured
//   into a reply register with a pending flag and an optional interrupt. The
//   block also owns the sound-CPU reset line.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   cs, addr, rd_n, wr_n   main-CPU bus access (strobes active low)
//   cpu_dout               main-CPU write data
//   dout                   registered read data
//   snd_latch, snd_stb     command byte to the sound CPU and its 1-cycle strobe
//   snd_flag               sound CPU has a command pending (not yet read)
//   main_latch, main_stb   reply byte from the sound CPU and its strobe
//   main_flag              reply pending for the main CPU
//   int_n                  main-CPU interrupt, active low
//   snd_rstn               sound-CPU reset, active low
module jtbubl_snd_comm #(
   parameter int unsigned FIFO_AW = 2,
   parameter int unsigned TOUT    = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic [1:0] addr,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic [7:0] cpu_dout,
   output logic [7:0] dout,
   output logic [7:0] snd_latch,
   output logic       snd_stb,
   input  logic       snd_flag,
   input  logic [7:0] main_latch,
   input  logic       main_stb,
   output logic       main_flag,
   output logic       int_n,
   output logic       snd_rstn
);

   localparam int unsigned Depth = 2 ** FIFO_AW;
   localparam int unsigned CntW  = $clog2(TOUT + 1);
   localparam logic [FIFO_AW:0] FullCnt = (FIFO_AW + 1)'(Depth);

   typedef enum logic [1:0] {StIdle, StSend, StAck, StDrain} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     tcnt_q, tcnt_d;

   logic                wr_l_q, rd_l_q;
   logic                wr_start, rd_start;
   logic                irq_en_q, cmd_ovf_q, rep_lost_q;
   logic [7:0]          reply_q, latch_q;

   logic [7:0]          mem [Depth];
   logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]    count_q;
   logic                empty, full;
   logic                push_req, push_ok, pop, flush, ovf_set;
   logic                ctrl_wr;

   // Side effects fire only on the first cycle of an access.
   assign wr_start = cs & ~wr_n & ~wr_l_q;
   assign rd_start = cs & ~rd_n & ~rd_l_q;
   assign ctrl_wr  = wr_start & (addr == 2'd1);

   assign empty    = (count_q == '0);
   assign full     = (count_q == FullCnt);

   // Holding the sound CPU in reset keeps the queue empty.
   assign flush    = (wr_start & (addr == 2'd2)) | ~snd_rstn;
   // A SEND whose byte was flushed away ends without a strobe.
   assign pop      = (state_q == StSend) & ~empty & snd_rstn;
   assign push_req = wr_start & (addr == 2'd0);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push_ok  = push_req & (~full | pop);
   assign ovf_set  = push_req & full & ~pop;

   assign snd_stb   = pop;
   assign snd_latch = pop ? mem[rd_ptr_q] : latch_q;
   assign int_n     = ~(irq_en_q & main_flag);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= cpu_dout;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         if (push_ok && !pop)      count_q <= count_q + (FIFO_AW + 1)'(1);
         else if (!push_ok && pop) count_q <= count_q - (FIFO_AW + 1)'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      if (!snd_rstn) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (!empty && !snd_flag) state_d = StSend;
            StSend: begin
               if (empty) begin
                  state_d = StIdle;
               end else begin
                  state_d = StAck;
                  tcnt_d  = '0;
               end
            end
            StAck: begin
               if (snd_flag) begin
                  state_d = StDrain;
               end else if (tcnt_q >= CntW'(TOUT - 1)) begin
                  // Counter reaches TOUT on this edge; the popped byte is given up.
                  state_d = StIdle;
                  tcnt_d  = CntW'(TOUT);
               end else begin
                  tcnt_d  = tcnt_q + CntW'(1);
               end
            end
            StDrain: if (!snd_flag) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         tcnt_q     <= '0;
         wr_l_q     <= 1'b0;
         rd_l_q     <= 1'b0;
         latch_q    <= 8'h00;
         snd_rstn   <= 1'b0;
         irq_en_q   <= 1'b0;
         cmd_ovf_q  <= 1'b0;
         rep_lost_q <= 1'b0;
         reply_q    <= 8'h00;
         main_flag  <= 1'b0;
         dout       <= 8'hFF;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         wr_l_q  <= cs & ~wr_n;
         rd_l_q  <= cs & ~rd_n;
         if (pop) latch_q <= mem[rd_ptr_q];

         if (ctrl_wr) begin
            snd_rstn <= ~cpu_dout[0];
            irq_en_q <= cpu_dout[1];
            if (cpu_dout[7]) begin
               cmd_ovf_q  <= 1'b0;
               rep_lost_q <= 1'b0;
            end
         end
         if (ovf_set) cmd_ovf_q <= 1'b1;

         // A new reply wins over a simultaneous read of the reply register.
         if (main_stb) begin
            reply_q   <= main_latch;
            main_flag <= 1'b1;
            if (main_flag) rep_lost_q <= 1'b1;
         end else if (rd_start && addr == 2'd0) begin
            main_flag <= 1'b0;
         end

         unique case (addr)
            2'd0:    dout <= reply_q;
            2'd1:    dout <= {~snd_rstn, irq_en_q, rep_lost_q, cmd_ovf_q,
                              full, empty, snd_flag, main_flag};
            default: dout <= 8'hFF;
         endcase
      end
   end

endmodule
